// File: rtl/game_state_controller_if.sv
// Switch/collision inputs and status outputs shared between the game-flow
// controller and the rest of the Frogger top level.
interface game_state_controller_if #(
    parameter int unsigned NUM_LIVES = 3,
    parameter int unsigned LEVEL_W   = 4
);
    logic                 i_Start;
    logic                 i_Pause;
    logic                 i_Collision;
    logic                 i_Level_Up;
    logic [2:0]           o_State;
    logic                 o_Game_Active;
    logic                 o_Paused;
    logic [NUM_LIVES-1:0] o_Lives;
    logic [LEVEL_W-1:0]   o_Level;
    logic                 o_Life_Lost;
    logic                 o_Respawn;
    logic                 o_Game_Over;
    logic                 o_Win;

    modport slave (
        input  i_Start, i_Pause, i_Collision, i_Level_Up,
        output o_State, o_Game_Active, o_Paused, o_Lives, o_Level,
               o_Life_Lost, o_Respawn, o_Game_Over, o_Win
    );

    modport master (
        output i_Start, i_Pause, i_Collision, i_Level_Up,
        input  o_State, o_Game_Active, o_Paused, o_Lives, o_Level,
               o_Life_Lost, o_Respawn, o_Game_Over, o_Win
    );
endinterface

// File: rtl/game_state_controller.sv
// Frogger session FSM: lives, levels, timed respawn freeze, game-over hold,
// pause and win handling.
module game_state_controller #(
    parameter int unsigned NUM_LIVES     = 3,
    parameter int unsigned NUM_LEVELS    = 10,
    parameter int unsigned LEVEL_W       = $clog2(NUM_LEVELS + 1),
    parameter int unsigned RESPAWN_TICKS = 25000000,
    parameter int unsigned OVER_TICKS    = 50000000,
    parameter int unsigned TIMER_W       = 26
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_L,
    game_state_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RUNNING   = 3'd1,
        S_RESPAWN   = 3'd2,
        S_GAME_OVER = 3'd3,
        S_WIN       = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_LIVES-1:0] lives_q, lives_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 start_prev_q, start_prev_d;
    logic                 coll_prev_q, coll_prev_d;
    logic                 life_lost_q, life_lost_d;
    logic                 respawn_q, respawn_d;

    logic                 start_edge;
    logic                 coll_edge;
    logic [LEVEL_W-1:0]   level_inc;

    assign start_edge = bus.i_Start & ~start_prev_q;
    assign coll_edge  = bus.i_Collision & ~coll_prev_q;
    assign level_inc  = level_q + LEVEL_W'(1);

    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        level_d      = level_q;
        timer_d      = timer_q;
        start_prev_d = bus.i_Start;
        coll_prev_d  = bus.i_Collision;
        life_lost_d  = 1'b0;
        respawn_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    lives_d = '1;
                    level_d = '0;
                    state_d = S_RUNNING;
                end
            end

            S_RUNNING: begin
                // Collision takes priority; a simultaneous level-up is dropped.
                if (!bus.i_Pause) begin
                    if (coll_edge) begin
                        lives_d     = lives_q >> 1;
                        life_lost_d = 1'b1;
                        if (lives_q == NUM_LIVES'(1)) begin
                            state_d = S_GAME_OVER;
                            timer_d = TIMER_W'(OVER_TICKS - 1);
                        end else begin
                            state_d = S_RESPAWN;
                            timer_d = TIMER_W'(RESPAWN_TICKS - 1);
                        end
                    end else if (bus.i_Level_Up && (level_q < LEVEL_W'(NUM_LEVELS))) begin
                        level_d = level_inc;
                        if (level_inc == LEVEL_W'(NUM_LEVELS)) begin
                            state_d = S_WIN;
                        end
                    end
                end
            end

            S_RESPAWN: begin
                if (timer_q == '0) begin
                    respawn_d = 1'b1;
                    state_d   = S_RUNNING;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end

            S_GAME_OVER: begin
                lives_d = '0;
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end

            S_WIN: begin
                if (start_edge) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // start_prev resets high so switches held through reset cannot start a game.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q      <= S_IDLE;
            lives_q      <= '1;
            level_q      <= '0;
            timer_q      <= '0;
            start_prev_q <= 1'b1;
            coll_prev_q  <= 1'b0;
            life_lost_q  <= 1'b0;
            respawn_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            level_q      <= level_d;
            timer_q      <= timer_d;
            start_prev_q <= start_prev_d;
            coll_prev_q  <= coll_prev_d;
            life_lost_q  <= life_lost_d;
            respawn_q    <= respawn_d;
        end
    end

    assign bus.o_State       = state_q;
    assign bus.o_Game_Active = (state_q == S_RUNNING) & ~bus.i_Pause;
    assign bus.o_Paused      = (state_q == S_RUNNING) & bus.i_Pause;
    assign bus.o_Lives       = lives_q;
    assign bus.o_Level       = level_q;
    assign bus.o_Life_Lost   = life_lost_q;
    assign bus.o_Respawn     = respawn_q;
    assign bus.o_Game_Over   = (state_q == S_GAME_OVER);
    assign bus.o_Win         = (state_q == S_WIN);

endmodule

// File: tb/tb_game_state_controller.sv
// Directed self-checking bench for game_state_controller with small lives,
// level and timer settings so every phase is short.
module tb_game_state_controller;

    localparam int unsigned NUM_LIVES     = 3;
    localparam int unsigned NUM_LEVELS    = 4;
    localparam int unsigned LEVEL_W       = 3;
    localparam int unsigned RESPAWN_TICKS = 4;
    localparam int unsigned OVER_TICKS    = 3;

    localparam logic [31:0] ST_IDLE = 0, ST_RUN = 1, ST_RESP = 2, ST_OVER = 3, ST_WIN = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    game_state_controller_if #(.NUM_LIVES(NUM_LIVES), .LEVEL_W(LEVEL_W)) bus ();

    game_state_controller #(
        .NUM_LIVES    (NUM_LIVES),
        .NUM_LEVELS   (NUM_LEVELS),
        .LEVEL_W      (LEVEL_W),
        .RESPAWN_TICKS(RESPAWN_TICKS),
        .OVER_TICKS   (OVER_TICKS),
        .TIMER_W      (26)
    ) dut (
        .i_Clk  (clk),
        .i_Rst_L(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        rst_n           = 1'b0;
        bus.i_Start     = 1'b1;
        bus.i_Pause     = 1'b0;
        bus.i_Collision = 1'b0;
        bus.i_Level_Up  = 1'b0;
        repeat (3) tick();

        // 1: reset state, start held through reset, then a real start edge
        check("rst_state", 32'(bus.o_State), ST_IDLE);
        check("rst_lives", 32'(bus.o_Lives), 32'h7);
        check("rst_level", 32'(bus.o_Level), 32'h0);
        check("rst_pulses", 32'({bus.o_Life_Lost, bus.o_Respawn}), 32'h0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("held_start_idle", 32'(bus.o_State), ST_IDLE);
        bus.i_Start = 1'b0;
        tick();
        bus.i_Start = 1'b1;
        tick();
        check("start_run", 32'(bus.o_State), ST_RUN);
        check("start_lives", 32'(bus.o_Lives), 32'h7);
        check("start_level", 32'(bus.o_Level), 32'h0);
        check("start_active", 32'(bus.o_Game_Active), 32'h1);
        bus.i_Start = 1'b0;

        // 2: long collision level costs one life, 4-cycle respawn freeze
        bus.i_Collision = 1'b1;
        tick();
        check("coll_state", 32'(bus.o_State), ST_RESP);
        check("coll_lost", 32'(bus.o_Life_Lost), 32'h1);
        check("coll_lives", 32'(bus.o_Lives), 32'h3);
        check("coll_inactive", 32'(bus.o_Game_Active), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("resp_hold", 32'(bus.o_State), ST_RESP);
            check("resp_lost_once", 32'(bus.o_Life_Lost), 32'h0);
            check("resp_no_pulse", 32'(bus.o_Respawn), 32'h0);
        end
        tick();
        check("resp_exit_state", 32'(bus.o_State), ST_RUN);
        check("resp_exit_pulse", 32'(bus.o_Respawn), 32'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("coll_level_state", 32'(bus.o_State), ST_RUN);
            check("coll_level_lives", 32'(bus.o_Lives), 32'h3);
            check("coll_level_lost", 32'(bus.o_Life_Lost), 32'h0);
            check("resp_pulse_once", 32'(bus.o_Respawn), 32'h0);
        end
        bus.i_Collision = 1'b0;
        tick();

        // 3: two more edges -> 001 then 000 and game over
        bus.i_Collision = 1'b1;
        tick();
        bus.i_Collision = 1'b0;
        check("e2_lives", 32'(bus.o_Lives), 32'h1);
        check("e2_state", 32'(bus.o_State), ST_RESP);
        repeat (4) tick();
        check("e2_back_run", 32'(bus.o_State), ST_RUN);
        bus.i_Collision = 1'b1;
        tick();
        bus.i_Collision = 1'b0;
        check("e3_lives", 32'(bus.o_Lives), 32'h0);
        check("e3_state", 32'(bus.o_State), ST_OVER);
        check("e3_over", 32'(bus.o_Game_Over), 32'h1);
        check("e3_lost", 32'(bus.o_Life_Lost), 32'h1);
        bus.i_Start = 1'b1;
        tick();
        check("over_ignore_start", 32'(bus.o_State), ST_OVER);
        bus.i_Start = 1'b0;
        tick();
        check("over_cycle3", 32'(bus.o_Game_Over), 32'h1);
        tick();
        check("over_to_idle", 32'(bus.o_State), ST_IDLE);
        check("over_flag_clear", 32'(bus.o_Game_Over), 32'h0);

        // 4: four level-ups to win, win -> idle -> running
        bus.i_Start = 1'b1;
        tick();
        bus.i_Start = 1'b0;
        check("g2_state", 32'(bus.o_State), ST_RUN);
        check("g2_lives", 32'(bus.o_Lives), 32'h7);
        for (int i = 1; i <= 4; i++) begin
            bus.i_Level_Up = 1'b1;
            tick();
            bus.i_Level_Up = 1'b0;
            check("lvl_value", 32'(bus.o_Level), 32'(i));
        end
        check("win_state", 32'(bus.o_State), ST_WIN);
        check("win_flag", 32'(bus.o_Win), 32'h1);
        bus.i_Level_Up = 1'b1;
        tick();
        bus.i_Level_Up = 1'b0;
        check("win_level_cap", 32'(bus.o_Level), 32'h4);
        bus.i_Start = 1'b1;
        tick();
        bus.i_Start = 1'b0;
        check("win_to_idle", 32'(bus.o_State), ST_IDLE);
        tick();
        bus.i_Start = 1'b1;
        tick();
        bus.i_Start = 1'b0;
        check("g3_state", 32'(bus.o_State), ST_RUN);
        check("g3_level", 32'(bus.o_Level), 32'h0);
        check("g3_lives", 32'(bus.o_Lives), 32'h7);

        // 5: pause discards collision and level-up
        bus.i_Pause = 1'b1;
        tick();
        check("pause_active", 32'(bus.o_Game_Active), 32'h0);
        check("pause_flag", 32'(bus.o_Paused), 32'h1);
        bus.i_Collision = 1'b1;
        tick();
        bus.i_Collision = 1'b0;
        bus.i_Level_Up  = 1'b1;
        tick();
        bus.i_Level_Up  = 1'b0;
        tick();
        check("pause_state", 32'(bus.o_State), ST_RUN);
        check("pause_lives", 32'(bus.o_Lives), 32'h7);
        check("pause_level", 32'(bus.o_Level), 32'h0);
        check("pause_no_lost", 32'(bus.o_Life_Lost), 32'h0);
        bus.i_Pause = 1'b0;
        tick();
        check("unpause_active", 32'(bus.o_Game_Active), 32'h1);
        check("unpause_flag", 32'(bus.o_Paused), 32'h0);

        // 6: collision beats simultaneous level-up; reset mid-respawn
        bus.i_Level_Up = 1'b1;
        tick();
        bus.i_Level_Up = 1'b0;
        check("pre_tie_level", 32'(bus.o_Level), 32'h1);
        bus.i_Level_Up  = 1'b1;
        bus.i_Collision = 1'b1;
        tick();
        bus.i_Level_Up  = 1'b0;
        bus.i_Collision = 1'b0;
        check("tie_level", 32'(bus.o_Level), 32'h1);
        check("tie_lives", 32'(bus.o_Lives), 32'h3);
        check("tie_state", 32'(bus.o_State), ST_RESP);
        tick();
        rst_n = 1'b0;
        #1;
        check("async_rst_state", 32'(bus.o_State), ST_IDLE);
        check("async_rst_lives", 32'(bus.o_Lives), 32'h7);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("async_rst_no_resp", 32'(bus.o_Respawn), 32'h0);
        end
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", 32'(bus.o_State), ST_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
